am_similarity_accumulator: RTL and testbench
============================================

Name: am_similarity_accumulator

Overview:
- Upstream stage of the associative-memory class comparator. For each of NUM_CLASSES stored class hypervectors, it computes the similarity to the query hypervector as the count of matching bits (XNOR popcount).
- Works chunk by chunk over DIM dimensions. It streams chunk addresses to the query and class memories and accumulates per-class counts.
- When all counts are final, it asserts inferring_class for exactly one cycle, which the comparator uses as its capture enable.

Parameters:
- NUM_CLASSES, 26, number of class hypervectors and similarity outputs
- DIM, 5000, hypervector dimensionality; must be a multiple of CHUNK_W
- CHUNK_W, 100, bits processed per cycle; NUM_CHUNKS = DIM/CHUNK_W (50 by default)
- SIM_W, 13, similarity width; must satisfy SIM_W >= clog2(DIM+1)

Ports:
- clk  input  1  clock
- nrst  input  1  asynchronous active-low reset
- start  input  1  request a new similarity pass; sampled only in IDLE
- mem_rd_en  output  1  read strobe to the query and class memories
- chunk_addr  output  clog2(NUM_CHUNKS)  chunk index being read
- query_chunk  input  CHUNK_W  query bits for the address issued one cycle earlier
- class_chunks  input  [0:NUM_CLASSES-1][CHUNK_W]  class bits for the address issued one cycle earlier
- busy  output  1  high in RUN, DRAIN and DONE
- inferring_class  output  1  one-cycle pulse; similarity_values are final
- similarity_values  output  [0:NUM_CLASSES-1][SIM_W]  per-class match counts

Behaviour:
- Reset (nrst low, asynchronous): state=IDLE; mem_rd_en=0, chunk_addr=0, busy=0, inferring_class=0; all similarity_values=0; read-valid pipeline flag cleared. Reset mid-pass abandons the pass with no partial pulse.
- Memory contract: fixed 1-cycle read latency. Data for the address presented in cycle k is valid in cycle k+1. An internal rd_valid_q flag equals mem_rd_en delayed by one cycle.
- FSM states:
  - IDLE: start=1 at edge T → clear all accumulators, go to RUN with chunk_addr=0.
  - RUN: mem_rd_en=1 and chunk_addr increments by 1 each cycle. Cycles T+1..T+NUM_CHUNKS carry addresses 0..NUM_CHUNKS-1. After address NUM_CHUNKS-1 is issued → DRAIN; chunk_addr returns to 0 and does not wrap further.
  - DRAIN: mem_rd_en=0; the last chunk is accumulated → DONE.
  - DONE: inferring_class=1 for this single cycle (cycle T+NUM_CHUNKS+2) → IDLE.
- Accumulation: on each edge where rd_valid_q=1, every class c updates as acc[c] += popcount(~(query_chunk ^ class_chunks[c])).
  - Popcount is combinational, CHUNK_W wide, with result width clog2(CHUNK_W+1).
  - Sums are zero-extended to SIM_W. No overflow is possible because the maximum is DIM.
- Output stability: similarity_values are driven directly from the accumulators. They are stable during DONE and hold through IDLE until the next accepted start clears them. They are not guaranteed meaningful during RUN or DRAIN.
- start handling:
  - start while busy=1 (including during DONE) is ignored and not queued.
  - start held high continuously produces back-to-back passes, one every NUM_CHUNKS+3 cycles.
- Boundary cases:
  - Identical hypervectors give DIM.
  - Complementary hypervectors give 0.

Optional Feature:
- Macro: AM_PRUNE_MASK_EN.
- Defined:
  - Adds input port prune_mask_chunk [CHUNK_W], read from the mask memory at the same chunk_addr with the same 1-cycle latency.
  - Accumulated value becomes popcount(~(query ^ class) & prune_mask_chunk). A mask bit of 0 means that dimension is pruned and not counted.
  - The mask is shared by all classes.
- Undefined: the port is absent and all dimensions are counted.

Test Plan:
- Query all ones; class 3 all ones, all others all zeros; pulse start at T → inferring_class high only at T+52. sim[3]=5000, all others 0; downstream comparator reports class 3.
- Query equals class 7 except 10 bits flipped in chunk 49; all other classes random → sim[7]=4990. This proves the last chunk is accumulated in DRAIN.
- Start pulsed again at T+10 and at T+52 (DONE) → both ignored; exactly one pulse at T+52; values unchanged.
- nrst asserted while chunk_addr=20 → all outputs 0 immediately and state IDLE. A following start yields correct full results with no stale counts.
- start held high for 3 passes with different memory contents → pulses at T+52, T+105, T+158. Each result matches only its own pass.
- With AM_PRUNE_MASK_EN: mask=0 for chunks 0–24 and all ones for chunks 25–49, query identical to class 0 → sim[0]=2500. Class all-zeros against all-zeros query → 2500.

Source files
------------

// File: rtl/am_similarity_accumulator_if.sv
// Memory-read and result bus between the similarity accumulator and its environment.
// The AM_PRUNE_MASK_EN build adds the shared prune-mask chunk.
interface am_similarity_accumulator_if #(
  parameter int unsigned NUM_CLASSES = 26,
  parameter int unsigned CHUNK_W     = 100,
  parameter int unsigned SIM_W       = 13,
  parameter int unsigned ADDR_W      = 6
);
  logic                                start;
  logic                                mem_rd_en;
  logic [ADDR_W-1:0]                   chunk_addr;
  logic [CHUNK_W-1:0]                  query_chunk;
  logic [0:NUM_CLASSES-1][CHUNK_W-1:0] class_chunks;
`ifdef AM_PRUNE_MASK_EN
  logic [CHUNK_W-1:0]                  prune_mask_chunk;
`endif
  logic                                busy;
  logic                                inferring_class;
  logic [0:NUM_CLASSES-1][SIM_W-1:0]   similarity_values;

  modport master (
`ifdef AM_PRUNE_MASK_EN
    output prune_mask_chunk,
`endif
    output start, query_chunk, class_chunks,
    input  mem_rd_en, chunk_addr, busy, inferring_class, similarity_values
  );

  modport slave (
`ifdef AM_PRUNE_MASK_EN
    input  prune_mask_chunk,
`endif
    input  start, query_chunk, class_chunks,
    output mem_rd_en, chunk_addr, busy, inferring_class, similarity_values
  );
endinterface

// File: rtl/am_similarity_accumulator.sv
// Streams chunk addresses to the query/class memories and accumulates per-class XNOR popcounts.
// Optional macro AM_PRUNE_MASK_EN: a shared mask chunk gates which dimensions are counted.
module am_similarity_accumulator #(
  parameter int unsigned NUM_CLASSES = 26,
  parameter int unsigned DIM         = 5000,
  parameter int unsigned CHUNK_W     = 100,
  parameter int unsigned SIM_W       = 13
) (
  input logic                        clk,
  input logic                        nrst,
  am_similarity_accumulator_if.slave bus
);
  localparam int unsigned NUM_CHUNKS = DIM / CHUNK_W;
  localparam int unsigned ADDR_W     = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int unsigned PC_W       = $clog2(CHUNK_W + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CHUNKS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]                        state_q, state_d;
  logic [ADDR_W-1:0]                 addr_q, addr_d;
  logic                              rd_en_q, rd_en_d;
  logic                              busy_q, busy_d;
  logic                              infer_q, infer_d;
  logic                              rd_valid_q;
  logic                              accept;
  logic [CHUNK_W-1:0]                mask;
  logic [0:NUM_CLASSES-1][PC_W-1:0]  pc;
  logic [0:NUM_CLASSES-1][SIM_W-1:0] acc_q;

  function automatic logic [PC_W-1:0] popcount(input logic [CHUNK_W-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < CHUNK_W; i++) n = n + PC_W'(v[i]);
    return n;
  endfunction

`ifdef AM_PRUNE_MASK_EN
  assign mask = bus.prune_mask_chunk;
`else
  assign mask = '1;
`endif

  assign accept = (state_q == IDLE) && bus.start;

  // Next-state and next-output logic; all outputs leave through registers.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rd_en_d = 1'b0;
    infer_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          addr_d  = '0;
          rd_en_d = 1'b1;
        end
      end
      RUN: begin
        if (addr_q == LAST_ADDR) begin
          state_d = DRAIN;
          addr_d  = '0;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          rd_en_d = 1'b1;
        end
      end
      DRAIN: begin
        state_d = DONE;
        infer_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      infer_q    <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
      infer_q    <= infer_d;
      rd_valid_q <= rd_en_q;
    end
  end

  // Per-class matching-bit count of the chunk returned by memory this cycle.
  always_comb begin
    pc = '0;
    for (int unsigned c = 0; c < NUM_CLASSES; c++)
      pc[c] = popcount(~(bus.query_chunk ^ bus.class_chunks[c]) & mask);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc_q <= '0;
    end else if (accept) begin
      acc_q <= '0;
    end else if (rd_valid_q) begin
      for (int unsigned c = 0; c < NUM_CLASSES; c++)
        acc_q[c] <= acc_q[c] + SIM_W'(pc[c]);
    end
  end

  assign bus.mem_rd_en         = rd_en_q;
  assign bus.chunk_addr        = addr_q;
  assign bus.busy              = busy_q;
  assign bus.inferring_class   = infer_q;
  assign bus.similarity_values = acc_q;
endmodule

// File: tb/tb_am_similarity_accumulator.sv
// Self-checking bench for am_similarity_accumulator: memory model, pass-level reference model,
// per-cycle compare process and directed scenarios with literal expectations.
module tb_am_similarity_accumulator;
  localparam int unsigned NUM_CLASSES = 26;
  localparam int unsigned DIM         = 5000;
  localparam int unsigned CHUNK_W     = 100;
  localparam int unsigned SIM_W       = 13;
  localparam int unsigned NUM_CHUNKS  = DIM / CHUNK_W;
  localparam int unsigned ADDR_W      = 6;
  localparam int          FINAL       = NUM_CHUNKS + 2;

  logic clk = 1'b0;
  logic nrst = 1'b1;
  always #5 clk = ~clk;

  am_similarity_accumulator_if #(
    .NUM_CLASSES(NUM_CLASSES), .CHUNK_W(CHUNK_W), .SIM_W(SIM_W), .ADDR_W(ADDR_W)
  ) bus ();

  am_similarity_accumulator #(
    .NUM_CLASSES(NUM_CLASSES), .DIM(DIM), .CHUNK_W(CHUNK_W), .SIM_W(SIM_W)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  logic [CHUNK_W-1:0] qmem [NUM_CHUNKS];
  logic [CHUNK_W-1:0] cmem [NUM_CLASSES][NUM_CHUNKS];
  logic [CHUNK_W-1:0] mmem [NUM_CHUNKS];

  int n_tests = 0;
  int n_fail  = 0;

  int m_cnt = 0;
  logic [0:NUM_CLASSES-1][SIM_W-1:0] exp_sim = '0;

  function automatic logic [CHUNK_W-1:0] rnd();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[CHUNK_W-1:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: one-cycle read latency, garbage on cycles with no read.
  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      bus.query_chunk <= qmem[bus.chunk_addr];
      for (int c = 0; c < NUM_CLASSES; c++) bus.class_chunks[c] <= cmem[c][bus.chunk_addr];
`ifdef AM_PRUNE_MASK_EN
      bus.prune_mask_chunk <= mmem[bus.chunk_addr];
`endif
    end else begin
      bus.query_chunk <= rnd();
      for (int c = 0; c < NUM_CLASSES; c++) bus.class_chunks[c] <= rnd();
`ifdef AM_PRUNE_MASK_EN
      bus.prune_mask_chunk <= rnd();
`endif
    end
  end

  function automatic logic [CHUNK_W-1:0] mask_at(input int k);
`ifdef AM_PRUNE_MASK_EN
    return mmem[k];
`else
    if (k < 0) return '0;
    return '1;
`endif
  endfunction

  // Whole-hypervector similarity of every class, taken from memory when a pass is accepted.
  task automatic snapshot();
    int cnt;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      cnt = 0;
      for (int k = 0; k < NUM_CHUNKS; k++)
        cnt += $countones(~(qmem[k] ^ cmem[c][k]) & mask_at(k));
      exp_sim[c] = SIM_W'(cnt);
    end
  endtask

  // Pass model: m_cnt = cycles since the accepted start, 0 when idle.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_cnt   = 0;
      exp_sim = '0;
    end else if (m_cnt == 0) begin
      if (bus.start) begin
        m_cnt = 1;
        snapshot();
      end
    end else if (m_cnt == FINAL) begin
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
  end

  always @(negedge clk) begin
    logic e_rd;
    int   e_addr;
    e_rd   = (m_cnt >= 1) && (m_cnt <= NUM_CHUNKS);
    e_addr = e_rd ? m_cnt - 1 : 0;
    check("cyc_busy", 64'(bus.busy), 64'(m_cnt != 0));
    check("cyc_rd_en", 64'(bus.mem_rd_en), 64'(e_rd));
    check("cyc_addr", 64'(bus.chunk_addr), 64'(e_addr));
    check("cyc_infer", 64'(bus.inferring_class), 64'(m_cnt == FINAL));
    if (m_cnt == 0 || m_cnt == FINAL) begin
      n_tests++;
      if (bus.similarity_values !== exp_sim) begin
        n_fail++;
        $display("FAIL cyc_sims: got %h expected %h (t=%0t)", bus.similarity_values, exp_sim, $time);
      end
    end
  end

  task automatic set_query(input logic [CHUNK_W-1:0] v);
    for (int k = 0; k < NUM_CHUNKS; k++) qmem[k] = v;
  endtask

  task automatic set_class(input int c, input logic [CHUNK_W-1:0] v);
    for (int k = 0; k < NUM_CHUNKS; k++) cmem[c][k] = v;
  endtask

  task automatic rand_all();
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      qmem[k] = rnd();
      for (int c = 0; c < NUM_CLASSES; c++) cmem[c][k] = rnd();
    end
  endtask

  task automatic b2b_pattern(input int p);
    set_query('1);
    for (int c = 0; c < NUM_CLASSES; c++) set_class(c, '0);
    set_class(20 + p, '1);
  endtask

  // Pulse start for one cycle and return the cycle (relative to the sampling edge) of the pulse.
  task automatic do_pass(output int cyc);
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    cyc = 1;
    while (!bus.inferring_class && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_rd_en"}, 64'(bus.mem_rd_en), 64'd0);
    check({tag, "_addr"}, 64'(bus.chunk_addr), 64'd0);
    check({tag, "_infer"}, 64'(bus.inferring_class), 64'd0);
    check({tag, "_sims_any"}, 64'(|bus.similarity_values), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int pulses;
    int pcyc;
    int p;
    int pcs [3];
    logic [SIM_W-1:0] s7;
    logic [SIM_W-1:0] s_own [3];
    logic [SIM_W-1:0] s_other [3];
    logic [CHUNK_W-1:0] flip;

    bus.start = 1'b0;
    for (int k = 0; k < NUM_CHUNKS; k++) mmem[k] = '1;
    set_query('0);
    for (int c = 0; c < NUM_CLASSES; c++) set_class(c, '0);
    #1 nrst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    #2 nrst = 1'b1;

    // Query all ones, only class 3 all ones.
    set_query('1);
    set_class(3, '1);
    do_pass(cyc);
    check("A_pulse_cyc", 64'(cyc), 64'd52);
    check("A_sim3", 64'(bus.similarity_values[3]), 64'd5000);
    check("A_sim0", 64'(bus.similarity_values[0]), 64'd0);
    check("A_sim25", 64'(bus.similarity_values[25]), 64'd0);
    check("A_model_sim3", 64'(exp_sim[3]), 64'd5000);

    // Class 7 = query with 10 bits flipped in the last chunk; starts at T+10 and T+52 ignored.
    rand_all();
    flip = '0;
    flip[9:0] = '1;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      cmem[7][k] = qmem[k];
      cmem[0][k] = ~qmem[k];
      cmem[1][k] = qmem[k];
    end
    cmem[7][NUM_CHUNKS-1] = qmem[NUM_CHUNKS-1] ^ flip;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    pulses = 0;
    pcyc = 0;
    s7 = '0;
    for (int c = 1; c <= 70; c++) begin
      bus.start = (c == 10);
      if (bus.inferring_class) begin
        pulses++;
        pcyc = c;
        bus.start = 1'b1;
        s7 = bus.similarity_values[7];
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("B_pulses", 64'(pulses), 64'd1);
    check("B_pulse_cyc", 64'(pcyc), 64'd52);
    check("B_sim7_at_pulse", 64'(s7), 64'd4990);
    check("B_sim7_held", 64'(bus.similarity_values[7]), 64'd4990);
    check("B_sim0_compl", 64'(bus.similarity_values[0]), 64'd0);
    check("B_sim1_ident", 64'(bus.similarity_values[1]), 64'd5000);
    check("B_model_sim7", 64'(exp_sim[7]), 64'd4990);
    check("B_idle_busy", 64'(bus.busy), 64'd0);

    // Reset in the middle of a pass, then a clean pass.
    rand_all();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    repeat (20) @(negedge clk);
    check("R_addr_before", 64'(bus.chunk_addr), 64'd20);
    #2 nrst = 1'b0;
    #1 check_all_zero("R_midreset");
    @(negedge clk);
    #2 nrst = 1'b1;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      cmem[12][k] = qmem[k];
      cmem[13][k] = ~qmem[k];
    end
    do_pass(cyc);
    check("R_pulse_cyc", 64'(cyc), 64'd52);
    check("R_sim12", 64'(bus.similarity_values[12]), 64'd5000);
    check("R_sim13", 64'(bus.similarity_values[13]), 64'd0);

    // Start held high for three back-to-back passes with different contents.
    b2b_pattern(0);
    for (int i = 0; i < 3; i++) begin
      pcs[i] = 0;
      s_own[i] = '1;
      s_other[i] = '1;
    end
    p = 0;
    @(negedge clk) bus.start = 1'b1;
    for (int c = 1; c <= 170 && p < 3; c++) begin
      @(negedge clk);
      if (bus.inferring_class) begin
        pcs[p] = c;
        s_own[p] = bus.similarity_values[20 + p];
        s_other[p] = bus.similarity_values[20 + ((p + 1) % 3)];
        p++;
        if (p < 3) b2b_pattern(p);
        else bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check("C_pulse0", 64'(pcs[0]), 64'd52);
    check("C_pulse1", 64'(pcs[1]), 64'd105);
    check("C_pulse2", 64'(pcs[2]), 64'd158);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("C_own%0d", i), 64'(s_own[i]), 64'd5000);
      check($sformatf("C_other%0d", i), 64'(s_other[i]), 64'd0);
    end

`ifdef AM_PRUNE_MASK_EN
    // First half of the dimensions pruned.
    repeat (3) @(negedge clk);
    for (int k = 0; k < NUM_CHUNKS; k++) mmem[k] = (k < 25) ? '0 : '1;
    rand_all();
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      cmem[0][k] = qmem[k];
      cmem[2][k] = ~qmem[k];
    end
    do_pass(cyc);
    check("M_pulse_cyc", 64'(cyc), 64'd52);
    check("M_sim0", 64'(bus.similarity_values[0]), 64'd2500);
    check("M_sim2", 64'(bus.similarity_values[2]), 64'd0);
    check("M_model_sim0", 64'(exp_sim[0]), 64'd2500);
    set_query('0);
    set_class(4, '0);
    do_pass(cyc);
    check("M_zero_sim4", 64'(bus.similarity_values[4]), 64'd2500);
`endif

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
